// File: rtl/memory_burst.sv
// rtl/memory_burst.sv - fixed-latency word memory with single/burst access and range checking
module memory_burst #(
    parameter int BIT_W  = 32,
    parameter int SIZE   = 4096,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 4,
    parameter int RD_LAT = 10,
    parameter int WR_LAT = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cen,
    input  logic                      i_wen,
    input  logic                      i_burst,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [BIT_W*LINE_W-1:0]   i_wdata,
    input  logic [BIT_W/8*LINE_W-1:0] i_wmask,
    input  logic [ADDR_W-1:0]         i_offset,
    input  logic [ADDR_W-1:0]         i_ubound,
    output logic [BIT_W*LINE_W-1:0]   o_rdata,
    output logic                      o_rvalid,
    output logic                      o_err,
    output logic                      o_stall
);
    localparam int BYTES = BIT_W / 8;
    localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DEPTH = 1 << IW;
    localparam logic [7:0]        RD_CNT = 8'(RD_LAT);
    localparam logic [7:0]        WR_CNT = 8'(WR_LAT);
    localparam logic [ADDR_W+1:0] SIZE_X = (ADDR_W+2)'(SIZE);
    localparam logic [ADDR_W+1:0] TAIL_X = (ADDR_W+2)'(LINE_W - 1);

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

    state_t                   state, state_next;
    logic [7:0]               cnt;
    logic                     burst_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [BIT_W*LINE_W-1:0]  wdata_q;
    logic [BYTES*LINE_W-1:0]  wmask_q;

    // A word reads as zero until written since the last reset; this stands in
    // for clearing the whole array on reset.
    logic [BIT_W-1:0]         mem [DEPTH];
    logic [DEPTH-1:0]         written;

    logic [ADDR_W:0]          diff, idx_full;
    logic [ADDR_W+1:0]        last;
    logic                     ok, done;
    logic [IW-1:0]            lane_addr [LINE_W];
    logic [BIT_W-1:0]         old_word  [LINE_W];
    logic [BIT_W-1:0]         new_word  [LINE_W];

    always_comb begin
        diff     = {1'b0, addr_q} - {1'b0, i_offset};
        idx_full = diff >> 2;
        last     = {1'b0, idx_full} + (burst_q ? TAIL_X : '0);
        ok       = !diff[ADDR_W] && (addr_q < i_ubound) && (last < SIZE_X);
    end

    always_comb begin
        for (int k = 0; k < LINE_W; k++) begin
            lane_addr[k] = idx_full[IW-1:0] + IW'(k);
            old_word[k]  = written[lane_addr[k]] ? mem[lane_addr[k]] : '0;
            new_word[k]  = old_word[k];
            for (int b = 0; b < BYTES; b++) begin
                if (wmask_q[k*BYTES+b])
                    new_word[k][8*b +: 8] = wdata_q[k*BIT_W+8*b +: 8];
            end
        end
    end

    assign done = (state == RD_BUSY && cnt == RD_CNT) || (state == WR_BUSY && cnt == WR_CNT);

    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        o_rvalid   = 1'b0;
        o_err      = 1'b0;
        o_rdata    = '0;
        case (state)
            IDLE: begin
                if (i_cen) begin
                    state_next = i_wen ? WR_BUSY : RD_BUSY;
                    o_stall    = 1'b1;
                end
            end
            RD_BUSY, WR_BUSY: begin
                if (done) begin
                    state_next = IDLE;
                    o_err      = !ok;
                    o_rvalid   = ok && (state == RD_BUSY);
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (o_rvalid) begin
            for (int k = 0; k < LINE_W; k++) begin
                if (k == 0 || burst_q)
                    o_rdata[k*BIT_W +: BIT_W] = old_word[k];
            end
        end
        if (i_rst) begin
            o_stall  = 1'b0;
            o_rvalid = 1'b0;
            o_err    = 1'b0;
            o_rdata  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            written <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (i_cen) begin
                    cnt     <= 8'd1;
                    burst_q <= i_burst;
                    addr_q  <= i_addr & ~ADDR_W'(3);
                    wdata_q <= i_wdata;
                    wmask_q <= i_wmask;
                end
            end else if (done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (state == WR_BUSY && done && ok) begin
                for (int k = 0; k < LINE_W; k++) begin
                    if (k == 0 || burst_q)
                        written[lane_addr[k]] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && state == WR_BUSY && done && ok) begin
            for (int k = 0; k < LINE_W; k++) begin
                if (k == 0 || burst_q)
                    mem[lane_addr[k]] <= new_word[k];
            end
        end
    end
endmodule

// File: tb/tb_memory_burst.sv
// tb/tb_memory_burst.sv - directed and randomized checks of memory_burst against a behavioural model
module tb_memory_burst;
    localparam int          SIZE   = 4096;
    localparam int          RD_LAT = 10;
    localparam int          WR_LAT = 5;
    localparam logic [31:0] OFFSET = 32'h10000;
    localparam logic [31:0] UBOUND = 32'h14000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cen, cen2, wen, burst;
    logic [31:0]  addr, offset, ubound;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic [127:0] rdata, rdata2;
    logic         rvalid, err, stall, rvalid2, err2, stall2;

    memory_burst dut (
        .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_wen(wen), .i_burst(burst),
        .i_addr(addr), .i_wdata(wdata), .i_wmask(wmask), .i_offset(offset), .i_ubound(ubound),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_err(err), .o_stall(stall)
    );

    memory_burst #(.SIZE(64), .RD_LAT(1), .WR_LAT(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_cen(cen2), .i_wen(wen), .i_burst(burst),
        .i_addr(addr), .i_wdata(wdata), .i_wmask(wmask), .i_offset(offset), .i_ubound(ubound),
        .o_rdata(rdata2), .o_rvalid(rvalid2), .o_err(err2), .o_stall(stall2)
    );

    int npass  = 0;
    int ntotal = 0;
    logic [31:0] mdl [SIZE];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < SIZE; i++) mdl[i] = '0;
    endtask

    // One request from an idle DUT, checked every cycle up to its completion.
    task automatic access(input bit w, input bit b, input logic [31:0] a,
                          input logic [127:0] wd, input logic [15:0] wm,
                          output logic [127:0] got_data, output logic got_err);
        int           lat = w ? WR_LAT : RD_LAT;
        int           n   = b ? 4 : 1;
        longint       wa  = longint'(a) & 64'hFFFF_FFFC;
        longint       idx = (wa - longint'(offset)) / 4;
        bit           ok  = (wa >= longint'(offset)) && (wa < longint'(ubound)) && (idx + n <= SIZE);
        logic [127:0] exp_data = '0;
        if (!w && ok)
            for (int k = 0; k < n; k++) exp_data[32*k +: 32] = mdl[int'(idx) + k];
        got_data = '0;
        got_err  = 1'b0;
        @(posedge clk); #1;
        cen = 1'b1; wen = w; burst = b; addr = a; wdata = wd; wmask = wm;
        @(negedge clk);
        check("stall_request", stall, 1'b1);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                cen   = 1'b0;
                wen   = 1'($urandom);
                burst = 1'($urandom);
                addr  = $urandom;
                wdata = {$urandom, $urandom, $urandom, $urandom};
                wmask = 16'($urandom);
            end
            @(negedge clk);
            check($sformatf("stall c%0d", c), stall, c != lat);
            check($sformatf("rvalid c%0d", c), rvalid, c == lat && !w && ok);
            check($sformatf("err c%0d", c), err, c == lat && !ok);
            check($sformatf("rdata c%0d", c), rdata, (c == lat) ? exp_data : '0);
            if (c == lat) begin
                got_data = rdata;
                got_err  = err;
            end
        end
        if (w && ok)
            for (int k = 0; k < n; k++)
                for (int bb = 0; bb < 4; bb++)
                    if (wm[4*k+bb]) mdl[int'(idx) + k][8*bb +: 8] = wd[32*k+8*bb +: 8];
    endtask

    initial begin
        logic [127:0] d;
        logic         e;
        logic [31:0]  ra;
        rst = 1'b1; cen = 1'b0; cen2 = 1'b0; wen = 1'b0; burst = 1'b0;
        addr = '0; wdata = '0; wmask = '0; offset = OFFSET; ubound = UBOUND;
        model_clear();
        repeat (2) @(posedge clk);
        #1; cen = 1'b1;
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, '0);
        @(posedge clk); #1; rst = 1'b0; cen = 1'b0;
        @(negedge clk);
        check("idle_stall", stall, 1'b0);
        check("idle_rdata", rdata, '0);

        access(1'b1, 1'b0, 32'h10008, 128'hDEADBEEF, 16'h000F, d, e);
        access(1'b0, 1'b0, 32'h10008, '0, '0, d, e);
        check("single_word", d, 128'hDEADBEEF);

        access(1'b1, 1'b1, 32'h10010, {32'd4, 32'd3, 32'd2, 32'd1}, 16'h00F3, d, e);
        access(1'b0, 1'b1, 32'h10010, '0, '0, d, e);
        check("burst_masked", d, {32'd0, 32'd0, 32'd2, 32'd1});

        access(1'b0, 1'b0, 32'h0FFFC, '0, '0, d, e);
        check("below_offset_err", e, 1'b1);
        access(1'b0, 1'b0, 32'h14000, '0, '0, d, e);
        check("at_ubound_err", e, 1'b1);
        access(1'b0, 1'b1, 32'(SIZE*4 - 8) + 32'h10000, '0, '0, d, e);
        check("burst_past_end_err", e, 1'b1);
        check("burst_past_end_data", d, '0);
        access(1'b1, 1'b1, 32'(SIZE*4 - 8) + 32'h10000, {4{32'hFFFFFFFF}}, 16'hFFFF, d, e);
        access(1'b0, 1'b0, 32'(SIZE*4 - 8) + 32'h10000, '0, '0, d, e);
        check("rejected_write_untouched", d, '0);

        @(posedge clk); #1;
        cen = 1'b1; wen = 1'b0; burst = 1'b1; addr = 32'h10010;
        for (int c = 0; c < 3 * (RD_LAT + 1); c++) begin
            @(negedge clk);
            check("hold_stall", stall, (c % (RD_LAT + 1)) != RD_LAT);
            check("hold_rvalid", rvalid, (c % (RD_LAT + 1)) == RD_LAT);
            check("hold_rdata", rdata,
                  ((c % (RD_LAT + 1)) == RD_LAT) ? {32'd0, 32'd0, 32'd2, 32'd1} : 128'd0);
            @(posedge clk); #1;
        end
        cen = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0)
                ra = OFFSET + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else
                ra = OFFSET - 32'd64 + 32'($urandom_range(0, SIZE*4 + 128));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                   {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), d, e);
        end

        @(posedge clk); #1;
        cen = 1'b1; wen = 1'b1; burst = 1'b0; addr = 32'h10020; wdata = 128'hCAFEF00D; wmask = 16'hF;
        @(posedge clk); #1; cen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", stall, 1'b0);
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_rdata", rdata, '0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("after_rst_rvalid", rvalid, 1'b0);
            check("after_rst_err", err, 1'b0);
            @(posedge clk); #1;
        end
        access(1'b0, 1'b0, 32'h10020, '0, '0, d, e);
        check("interrupted_write_absent", d, '0);
        access(1'b0, 1'b0, 32'h10008, '0, '0, d, e);
        check("reset_cleared_word", d, '0);

        @(posedge clk); #1;
        cen2 = 1'b1; wen = 1'b1; burst = 1'b0; addr = 32'h10004; wdata = 128'h12345678; wmask = 16'hF;
        @(negedge clk);
        check("lat1_req_stall", stall2, 1'b1);
        @(posedge clk); #1;
        wen = 1'b0; wdata = '0;
        @(negedge clk);
        check("lat1_wr_done_stall", stall2, 1'b0);
        check("lat1_wr_done_err", err2, 1'b0);
        check("lat1_wr_done_rvalid", rvalid2, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat1_b2b_stall", stall2, 1'b1);
        @(posedge clk); #1; cen2 = 1'b0;
        @(negedge clk);
        check("lat1_rd_rvalid", rvalid2, 1'b1);
        check("lat1_rd_data", rdata2, 128'h12345678);
        check("lat1_rd_stall", stall2, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat1_idle_rvalid", rvalid2, 1'b0);
        check("lat1_idle_rdata", rdata2, '0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
